// File: rtl/dbg_view_pkg.sv
// Shared types and constants for the debug register viewer.
//   viewer_state_t : capture FSM encoding (IDLE / WAIT / LATCH)
//   viewer_dbg_t   : debug snapshot of the FSM and its qualifying inputs
//   DBG_WORD_W     : width of the register file debug read port
//   cnt_w()        : counter width for a modulus, never below 1 bit
package dbg_view_pkg;

  localparam int DBG_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    LATCH = 2'd2
  } viewer_state_t;

  typedef struct packed {
    viewer_state_t state;
    logic          req;
    logic          frz;
    logic [2:0]    btn_level; // {next, prev, half} debounced levels
  } viewer_dbg_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a stability
// counter. The stable level flips only after the synchronized input has
// differed from it for STABLE_TICKS consecutive cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw button input (asynchronous to clk)
//   level      : debounced level
//   press      : one-cycle pulse on a debounced 0->1 transition
module btn_debounce
  import dbg_view_pkg::*;
#(
  parameter int STABLE_TICKS = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int                CNT_W   = cnt_w(STABLE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_TICKS - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  // The counter has run out while the input still disagrees: flip now.
  assign w_done = (r_sync1 != r_stable) && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync0 <= raw;
      r_sync1 <= r_sync0;
      if (r_sync1 == r_stable) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_stable;
  // Pulse coincides with the cycle in which the stable level rises.
  assign press = w_done & ~r_stable;

endmodule

// File: rtl/dbg_reg_viewer.sv
// Debug register viewer for the seven-segment display.
// Buttons step through registers and toggle the displayed half; the
// selected register is re-read periodically over the register file debug
// port and on every index change. A freeze switch holds the shown value.
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn_next     : raw button, index + 1 (wraps)
//   btn_prev     : raw button, index - 1 (wraps)
//   btn_half     : raw button, toggle upper/lower half
//   sw_freeze    : raw switch, 1 holds the displayed value
//   dbg_rd_addr  : register file debug read address (= sel_idx)
//   dbg_rd_data  : debug read data, valid one cycle after the address
//   REG_dbg      : selected 16-bit half of the captured word
//   sel_idx      : selected register index
//   half_sel     : 1 when the upper half is shown
//   dbg_status   : FSM state, pending request, freeze and button levels
//
// Capture handshake: dbg_rd_addr is held while the FSM is in WAIT, which
// gives the register file its one cycle of latency; the word is sampled on
// the WAIT->LATCH edge, so LATCH is the first cycle showing new data.
module dbg_reg_viewer
  import dbg_view_pkg::*;
#(
  parameter int TICKS_PER_MILLI = 100_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REFRESH_MS      = 50,
  parameter int NUM_REGS        = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_next,
  input  logic                        btn_prev,
  input  logic                        btn_half,
  input  logic                        sw_freeze,
  output logic [$clog2(NUM_REGS)-1:0] dbg_rd_addr,
  input  logic [DBG_WORD_W-1:0]       dbg_rd_data,
  output logic [15:0]                 REG_dbg,
  output logic [$clog2(NUM_REGS)-1:0] sel_idx,
  output logic                        half_sel,
  output viewer_dbg_t                 dbg_status
);

  localparam int IDX_W        = $clog2(NUM_REGS);
  localparam int STABLE_TICKS = DEBOUNCE_MS * TICKS_PER_MILLI;
  localparam int MS_W         = cnt_w(TICKS_PER_MILLI);
  localparam int REF_W        = cnt_w(REFRESH_MS);
  localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(TICKS_PER_MILLI - 1);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_MS - 1);

  // Button conditioning
  logic w_next_press, w_prev_press, w_half_press;
  logic w_next_level, w_prev_level, w_half_level;

  btn_debounce #(.STABLE_TICKS(STABLE_TICKS)) u_db_next (
    .clk(clk), .rst_n(rst_n), .raw(btn_next),
    .level(w_next_level), .press(w_next_press)
  );
  btn_debounce #(.STABLE_TICKS(STABLE_TICKS)) u_db_prev (
    .clk(clk), .rst_n(rst_n), .raw(btn_prev),
    .level(w_prev_level), .press(w_prev_press)
  );
  btn_debounce #(.STABLE_TICKS(STABLE_TICKS)) u_db_half (
    .clk(clk), .rst_n(rst_n), .raw(btn_half),
    .level(w_half_level), .press(w_half_press)
  );

  // Freeze switch: synchronized only; r_frz_d detects the release edge.
  logic r_frz_s0, r_frz_s1, r_frz_d;
  logic w_frz, w_frz_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frz_s0 <= 1'b0;
      r_frz_s1 <= 1'b0;
      r_frz_d  <= 1'b0;
    end else begin
      r_frz_s0 <= sw_freeze;
      r_frz_s1 <= r_frz_s0;
      r_frz_d  <= r_frz_s1;
    end
  end

  assign w_frz      = r_frz_s1;
  assign w_frz_fall = r_frz_d & ~r_frz_s1;

  // Refresh timer: ms prescaler feeding a refresh-period counter.
  logic [MS_W-1:0]  r_ms_cnt;
  logic [REF_W-1:0] r_ref_cnt;
  logic             w_ms_wrap, w_ref_wrap, w_tick;

  assign w_ms_wrap  = (r_ms_cnt == MS_MAX);
  assign w_ref_wrap = (r_ref_cnt == REF_MAX);
  assign w_tick     = w_ms_wrap & w_ref_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ms_cnt  <= '0;
      r_ref_cnt <= '0;
    end else if (w_ms_wrap) begin
      r_ms_cnt  <= '0;
      r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + REF_W'(1);
    end else begin
      r_ms_cnt <= r_ms_cnt + MS_W'(1);
    end
  end

  // Index and half select. NUM_REGS is a power of two, so the natural
  // IDX_W-bit overflow gives the required wrap in both directions.
  logic [IDX_W-1:0] r_sel_idx;
  logic             r_half_sel;
  logic             w_step_up, w_step_dn, w_idx_chg;

  assign w_step_up = w_next_press & ~w_prev_press;
  assign w_step_dn = w_prev_press & ~w_next_press;
  assign w_idx_chg = w_step_up | w_step_dn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_idx  <= '0;
      r_half_sel <= 1'b0;
    end else begin
      if (w_step_up)      r_sel_idx <= r_sel_idx + IDX_W'(1);
      else if (w_step_dn) r_sel_idx <= r_sel_idx - IDX_W'(1);
      if (w_half_press)   r_half_sel <= ~r_half_sel;
    end
  end

  // Capture FSM
  viewer_state_t r_state, w_state_nxt;
  logic          r_req;
  logic          w_req_set, w_enter_wait, w_capture;
  logic [DBG_WORD_W-1:0] r_word_q;

  // Freeze masks index/tick requests; releasing freeze always requests.
  assign w_req_set = ((w_idx_chg | w_tick) & ~w_frz) | w_frz_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (r_req && !w_frz) w_state_nxt = WAIT;
      WAIT:  w_state_nxt = LATCH;
      // A request raised this very cycle also counts, so a press landing
      // in LATCH goes straight back to WAIT.
      LATCH: w_state_nxt = ((r_req || w_req_set) && !w_frz) ? WAIT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_enter_wait = (r_state != WAIT) && (w_state_nxt == WAIT);
    w_capture    = (r_state == WAIT);
  end

  // A new request wins over the clear-on-entry, so an index change on the
  // edge that enters WAIT (whose address the port has not yet seen) still
  // leaves a follow-up read pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req    <= 1'b1;
      r_word_q <= '0;
    end else begin
      r_req <= w_req_set | (r_req & ~w_enter_wait);
      if (w_capture) r_word_q <= dbg_rd_data;
    end
  end

  assign dbg_rd_addr = r_sel_idx;
  assign sel_idx     = r_sel_idx;
  assign half_sel    = r_half_sel;
  assign REG_dbg     = r_half_sel ? r_word_q[31:16] : r_word_q[15:0];

  always_comb begin
    dbg_status           = '0;
    dbg_status.state     = r_state;
    dbg_status.req       = r_req;
    dbg_status.frz       = w_frz;
    dbg_status.btn_level = {w_next_level, w_prev_level, w_half_level};
  end

endmodule

// File: tb/tb_dbg_reg_viewer.sv
// Directed bench for dbg_reg_viewer with small timing parameters:
// 20-cycle debounce, 30-cycle refresh period, 32 registers.
module tb_dbg_reg_viewer;
  import dbg_view_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        btn_next, btn_prev, btn_half, sw_freeze;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] dbg_rd_data;
  logic [15:0] REG_dbg;
  logic [4:0]  sel_idx;
  logic        half_sel;
  viewer_dbg_t dbg_status;

  dbg_reg_viewer #(
    .TICKS_PER_MILLI(10), .DEBOUNCE_MS(2), .REFRESH_MS(3), .NUM_REGS(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_half(btn_half),
    .sw_freeze(sw_freeze),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .REG_dbg(REG_dbg), .sel_idx(sel_idx), .half_sel(half_sel),
    .dbg_status(dbg_status)
  );

  // Register file model: one cycle read latency.
  logic [31:0] mem [32];
  always @(posedge clk) dbg_rd_data <= mem[dbg_rd_addr];

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic do_next, input logic do_prev, input logic do_half);
    btn_next = do_next; btn_prev = do_prev; btn_half = do_half;
    tick(25);
    btn_next = 1'b0; btn_prev = 1'b0; btn_half = 1'b0;
    tick(25);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(5);
    n_checks++; if (REG_dbg !== 16'h0000) begin n_fail++; $display("FAIL rst_reg: got %h want 0000", REG_dbg); end
    n_checks++; if (sel_idx !== 5'd0) begin n_fail++; $display("FAIL rst_idx: got %0d want 0", sel_idx); end
    n_checks++; if (half_sel !== 1'b0) begin n_fail++; $display("FAIL rst_half: got %b want 0", half_sel); end
    n_checks++; if (dbg_rd_addr !== 5'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", dbg_rd_addr); end
    n_checks++; if (dbg_status.state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_status.state); end
    rst_n = 1'b1;
    tick(6);
    n_checks++; if (REG_dbg !== 16'h0000) begin n_fail++; $display("FAIL post_rst_reg: got %h want 0000", REG_dbg); end
    n_checks++; if (sel_idx !== 5'd0) begin n_fail++; $display("FAIL post_rst_idx: got %0d want 0", sel_idx); end
    press(1'b0, 1'b0, 1'b1);
    n_checks++; if (half_sel !== 1'b1) begin n_fail++; $display("FAIL half_on: got %b want 1", half_sel); end
    n_checks++; if (REG_dbg !== 16'hA000) begin n_fail++; $display("FAIL half_upper: got %h want A000", REG_dbg); end
    press(1'b0, 1'b0, 1'b1);
    n_checks++; if (REG_dbg !== 16'h0000) begin n_fail++; $display("FAIL half_lower: got %h want 0000", REG_dbg); end
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 12; i++) begin
      btn_next = (i % 2 == 0);
      tick(5);
    end
    btn_next = 1'b0;
    tick(30);
    n_checks++; if (sel_idx !== 5'd0) begin n_fail++; $display("FAIL bounce_idx: got %0d want 0", sel_idx); end
    press(1'b1, 1'b0, 1'b0);
    n_checks++; if (sel_idx !== 5'd1) begin n_fail++; $display("FAIL held_idx: got %0d want 1", sel_idx); end
    n_checks++; if (dbg_rd_addr !== 5'd1) begin n_fail++; $display("FAIL held_addr: got %0d want 1", dbg_rd_addr); end
    n_checks++; if (REG_dbg !== 16'h0001) begin n_fail++; $display("FAIL held_reg: got %h want 0001", REG_dbg); end
  endtask

  task automatic test_wrap_simul();
    logic [15:0] exp_v;
    press(1'b0, 1'b1, 1'b0);
    n_checks++; if (sel_idx !== 5'd0) begin n_fail++; $display("FAIL prev_to0: got %0d want 0", sel_idx); end
    exp_q.push_back(16'h001F);
    exp_q.push_back(16'h0000);
    press(1'b0, 1'b1, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++; if (sel_idx !== 5'd31) begin n_fail++; $display("FAIL wrap_down_idx: got %0d want 31", sel_idx); end
    n_checks++; if (REG_dbg !== exp_v) begin n_fail++; $display("FAIL wrap_down_reg: got %h want %h", REG_dbg, exp_v); end
    press(1'b1, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++; if (sel_idx !== 5'd0) begin n_fail++; $display("FAIL wrap_up_idx: got %0d want 0", sel_idx); end
    n_checks++; if (REG_dbg !== exp_v) begin n_fail++; $display("FAIL wrap_up_reg: got %h want %h", REG_dbg, exp_v); end
    press(1'b1, 1'b1, 1'b0);
    n_checks++; if (sel_idx !== 5'd0) begin n_fail++; $display("FAIL simul_idx: got %0d want 0", sel_idx); end
  endtask

  task automatic test_auto_refresh();
    bit hit;
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
    n_checks++; if (sel_idx !== 5'd5) begin n_fail++; $display("FAIL step5_idx: got %0d want 5", sel_idx); end
    n_checks++; if (REG_dbg !== 16'h0005) begin n_fail++; $display("FAIL step5_reg: got %h want 0005", REG_dbg); end
    mem[5] = 32'h1234_5678;
    hit = 1'b0;
    for (int i = 0; i < 34 && !hit; i++) begin
      tick(1);
      if (REG_dbg === 16'h5678) hit = 1'b1;
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL refresh_timeout: got %h want 5678", REG_dbg); end
  endtask

  task automatic test_freeze();
    bit hit;
    sw_freeze = 1'b1;
    tick(4);
    n_checks++; if (REG_dbg !== 16'h5678) begin n_fail++; $display("FAIL frz_hold0: got %h want 5678", REG_dbg); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    mem[7] = 32'hCAFE_BEEF;
    mem[5] = 32'h5555_AAAA;
    tick(35);
    n_checks++; if (REG_dbg !== 16'h5678) begin n_fail++; $display("FAIL frz_hold: got %h want 5678", REG_dbg); end
    n_checks++; if (sel_idx !== 5'd7) begin n_fail++; $display("FAIL frz_idx: got %0d want 7", sel_idx); end
    sw_freeze = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) begin
      tick(1);
      if (REG_dbg === 16'hBEEF) hit = 1'b1;
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL unfreeze_timeout: got %h want BEEF", REG_dbg); end
  endtask

  task automatic test_mid_capture();
    viewer_state_t prev_st;
    bit relatch;
    // Identical debouncers: the next press lands 3 cycles after the prev
    // press, i.e. in the LATCH cycle of the capture the prev press started.
    relatch = 1'b0;
    prev_st = dbg_status.state;
    btn_prev = 1'b1;
    tick(3);
    btn_next = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (prev_st == LATCH && dbg_status.state == WAIT) relatch = 1'b1;
      prev_st = dbg_status.state;
    end
    btn_prev = 1'b0;
    btn_next = 1'b0;
    tick(30);
    n_checks++; if (!relatch) begin n_fail++; $display("FAIL latch_to_wait: got 0 want 1"); end
    n_checks++; if (sel_idx !== 5'd7) begin n_fail++; $display("FAIL mid_idx: got %0d want 7", sel_idx); end
    n_checks++; if (REG_dbg !== 16'hBEEF) begin n_fail++; $display("FAIL mid_reg: got %h want BEEF", REG_dbg); end
  endtask

  task automatic test_reset_in_wait();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (dbg_status.state === WAIT) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL wait_timeout: got state %0d want 1", dbg_status.state); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (dbg_status.state !== IDLE) begin n_fail++; $display("FAIL rstw_state: got %0d want 0", dbg_status.state); end
    n_checks++; if (REG_dbg !== 16'h0000) begin n_fail++; $display("FAIL rstw_reg: got %h want 0000", REG_dbg); end
    n_checks++; if (sel_idx !== 5'd0) begin n_fail++; $display("FAIL rstw_idx: got %0d want 0", sel_idx); end
    tick(2);
    rst_n = 1'b1;
    tick(6);
    n_checks++; if (REG_dbg !== 16'h0000) begin n_fail++; $display("FAIL rstw_recap: got %h want 0000", REG_dbg); end
    n_checks++; if (dbg_status.state !== IDLE) begin n_fail++; $display("FAIL rstw_idle: got %0d want 0", dbg_status.state); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
    btn_next = 1'b0; btn_prev = 1'b0; btn_half = 1'b0; sw_freeze = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_debounce();
    test_wrap_simul();
    test_auto_refresh();
    test_freeze();
    test_mid_capture();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
